// File: rtl/svn_seg_pkg.sv
// Shared seven-segment definitions: bit indices, hex glyph codes, decode table, error bits.
package svn_seg_pkg;

    // Segment bit positions on the display bus
    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Active-high glyph codes, seg[6:0] = g..a
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_HEX_A = 7'h77;
    localparam logic [6:0] SEG_HEX_B = 7'h7C;
    localparam logic [6:0] SEG_HEX_C = 7'h39;
    localparam logic [6:0] SEG_HEX_D = 7'h5E;
    localparam logic [6:0] SEG_HEX_E = 7'h79;
    localparam logic [6:0] SEG_HEX_F = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Sticky error flag positions in err_o
    localparam int ERR_BAD   = 0;
    localparam int ERR_MULTI = 1;
    localparam int ERR_OVR   = 2;
    localparam int ERR_W     = 3;

    // Hex nibble -> glyph; the decoder searches this same table
    function automatic logic [6:0] seg_encode(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'h0: code = SEG_0;
            4'h1: code = SEG_1;
            4'h2: code = SEG_2;
            4'h3: code = SEG_3;
            4'h4: code = SEG_4;
            4'h5: code = SEG_5;
            4'h6: code = SEG_6;
            4'h7: code = SEG_7;
            4'h8: code = SEG_8;
            4'h9: code = SEG_9;
            4'hA: code = SEG_HEX_A;
            4'hB: code = SEG_HEX_B;
            4'hC: code = SEG_HEX_C;
            4'hD: code = SEG_HEX_D;
            4'hE: code = SEG_HEX_E;
            default: code = SEG_HEX_F;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/svn_seg_decode.sv
// Combinational glyph decoder: 7-bit active-high pattern -> {nibble, blank, legal}.
module svn_seg_decode
    import svn_seg_pkg::*;
(
    input  logic [6:0] pat,
    output logic [3:0] nibble,
    output logic       blank,
    output logic       legal
);

    // Search the hex table; blank is reported separately and decodes to nibble 0
    always_comb begin
        nibble = '0;
        legal  = 1'b0;
        blank  = (pat == SEG_BLANK);
        for (int i = 0; i < 16; i++) begin
            if (pat == seg_encode(4'(i))) begin
                nibble = 4'(i);
                legal  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/svn_seg_capture.sv
// Seven-segment bus receiver: samples the multiplexed bus, waits for a stable digit,
// rebuilds a full frame of nibbles and hands it out over valid/ready with sticky errors.
module svn_seg_capture
    import svn_seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int SEL_ACTIVE_LOW = 1,
    parameter int STABLE_CNT     = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [7:0]              display_i,
    input  logic [NUM_DIGITS-1:0]   seg_sel_i,
    output logic [4*NUM_DIGITS-1:0] digits_o,
    output logic [NUM_DIGITS-1:0]   dp_o,
    output logic [NUM_DIGITS-1:0]   blank_o,
    output logic                    frame_valid_o,
    input  logic                    frame_ready_i,
    output logic [ERR_W-1:0]        err_o,
    input  logic                    err_clr_i
);

    localparam int SW    = NUM_DIGITS + 8;
    localparam int CW    = 4;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [NUM_DIGITS-1:0]        sel_r, sel_n;
    logic [7:0]                   disp_r, disp_n;
    logic [SW-1:0]                prev_r;
    logic [CW-1:0]                cnt_r, cnt_nxt;
    logic                         commit;
    logic [3:0]                   n_sel;
    logic [IDX_W-1:0]             sel_idx;
    logic [3:0]                   dec_nib;
    logic                         dec_blank, dec_legal;
    logic                         wr_digit, complete, accept;
    logic [NUM_DIGITS-1:0]        seen_r, seen_nxt;
    logic [NUM_DIGITS-1:0][3:0]   sh_dig, out_dig;
    logic [NUM_DIGITS-1:0]        sh_dp, sh_blank, out_dp, out_blank;
    logic                         valid_r;
    logic [ERR_W-1:0]             err_r, err_set;

    // Register the raw bus once and keep the previous sample for the stability compare
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sel_r  <= '0;
            disp_r <= '0;
            prev_r <= '0;
        end else begin
            sel_r  <= seg_sel_i;
            disp_r <= display_i;
            prev_r <= {sel_r, disp_r};
        end
    end

    assign sel_n  = (SEL_ACTIVE_LOW != 0) ? ~sel_r  : sel_r;
    assign disp_n = (SEG_ACTIVE_LOW != 0) ? ~disp_r : disp_r;

    // Count identical samples, saturating at STABLE_CNT so a held digit commits once
    always_comb begin
        cnt_nxt = CW'(1);
        if ({sel_r, disp_r} == prev_r)
            cnt_nxt = (cnt_r == CW'(STABLE_CNT)) ? cnt_r : cnt_r + CW'(1);
        commit = (cnt_nxt == CW'(STABLE_CNT)) && (cnt_r != CW'(STABLE_CNT));
    end

    // Stability counter register
    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_r <= '0;
        else       cnt_r <= cnt_nxt;
    end

    // Population count and index of the selected digit
    always_comb begin
        n_sel   = '0;
        sel_idx = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (sel_n[k]) begin
                n_sel   = n_sel + 4'd1;
                sel_idx = IDX_W'(k);
            end
        end
    end

    svn_seg_decode u_dec (
        .pat    (disp_n[6:0]),
        .nibble (dec_nib),
        .blank  (dec_blank),
        .legal  (dec_legal)
    );

    assign wr_digit = commit && (n_sel == 4'd1) && (dec_legal || dec_blank);
    assign complete = &seen_r;
    assign accept   = valid_r && frame_ready_i;

    // Completion clears seen; a digit committed in that same cycle starts the next frame
    always_comb begin
        seen_nxt = complete ? '0 : seen_r;
        if (wr_digit) seen_nxt[sel_idx] = 1'b1;
    end

    // Error sources for this cycle
    always_comb begin
        err_set            = '0;
        err_set[ERR_BAD]   = commit && (n_sel == 4'd1) && !dec_legal && !dec_blank;
        err_set[ERR_MULTI] = commit && (n_sel > 4'd1);
        err_set[ERR_OVR]   = complete && valid_r && !frame_ready_i;
    end

    // Seen mask and per-digit shadow; latest commit of a digit wins
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            seen_r   <= '0;
            sh_dig   <= '0;
            sh_dp    <= '0;
            sh_blank <= '0;
        end else begin
            seen_r <= seen_nxt;
            if (wr_digit) begin
                sh_dig[sel_idx]   <= dec_nib;
                sh_dp[sel_idx]    <= disp_n[SEG_DP];
                sh_blank[sel_idx] <= dec_blank;
            end
        end
    end

    // Output frame: load when the slot is free or being taken; held frame wins on overrun
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_dig   <= '0;
            out_dp    <= '0;
            out_blank <= '0;
            valid_r   <= 1'b0;
        end else if (complete && (!valid_r || accept)) begin
            out_dig   <= sh_dig;
            out_dp    <= sh_dp;
            out_blank <= sh_blank;
            valid_r   <= 1'b1;
        end else if (accept) begin
            valid_r   <= 1'b0;
        end
    end

    // Sticky errors; a new error in the clear cycle keeps its bit set
    always_ff @(posedge clk_i) begin
        if (rst_i) err_r <= '0;
        else       err_r <= (err_clr_i ? '0 : err_r) | err_set;
    end

    assign digits_o      = out_dig;
    assign dp_o          = out_dp;
    assign blank_o       = out_blank;
    assign frame_valid_o = valid_r;
    assign err_o         = err_r;

endmodule

// File: tb/tb_svn_seg_capture.sv
// Directed bench for svn_seg_capture: scoreboard of expected frames popped on handshake.
module tb_svn_seg_capture;
    import svn_seg_pkg::*;

    localparam int ND = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [7:0]      display;
    logic [ND-1:0]   seg_sel;
    logic [4*ND-1:0] digits;
    logic [ND-1:0]   dp, blank;
    logic            frame_valid, frame_ready;
    logic [2:0]      err;
    logic            err_clr;

    int errors  = 0;
    int checks  = 0;
    int vcycles = 0;
    logic [23:0] exp_q[$];

    svn_seg_capture u_dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .display_i     (display),
        .seg_sel_i     (seg_sel),
        .digits_o      (digits),
        .dp_o          (dp),
        .blank_o       (blank),
        .frame_valid_o (frame_valid),
        .frame_ready_i (frame_ready),
        .err_o         (err),
        .err_clr_i     (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive an active-high select/pattern onto the active-low bus
    task automatic drive_raw(input logic [ND-1:0] sel_norm, input logic [6:0] pat,
                             input logic dpb, input int n);
        seg_sel = ~sel_norm;
        display = ~{dpb, pat};
        tick(n);
    endtask

    task automatic show(input int k, input logic [3:0] nib, input int n);
        drive_raw(ND'(1) << k, seg_encode(nib), 1'b0, n);
    endtask

    task automatic idle(input int n);
        seg_sel = '1;
        display = '1;
        tick(n);
    endtask

    task automatic show_frame(input logic [15:0] v);
        for (int k = 0; k < ND; k++) show(k, v[4*k +: 4], 5);
    endtask

    // Consumer side: every accepted frame must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && frame_valid) vcycles++;
        if (!rst && frame_valid && frame_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_frame: got %h expected none", {digits, dp, blank});
            end else begin
                check("frame", {8'h00, digits, dp, blank}, {8'h00, exp_q.pop_front()});
            end
        end
    end

    initial begin
        rst = 1'b1; frame_ready = 1'b1; err_clr = 1'b0;
        seg_sel = '1; display = '1;
        tick(3);
        check("rst_digits", 32'(digits), 32'h0);
        check("rst_dp", 32'(dp), 32'h0);
        check("rst_blank", 32'(blank), 32'h0);
        check("rst_valid", 32'(frame_valid), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        rst = 1'b0;
        tick(3);

        // Basic frame, consumer always ready
        vcycles = 0;
        exp_q.push_back({16'h4321, 4'h0, 4'h0});
        show_frame(16'h4321);
        idle(6);
        check("t1_valid_cycles", 32'(vcycles), 32'd1);
        check("t1_valid_low", 32'(frame_valid), 32'h0);
        check("t1_digits", 32'(digits), 32'h4321);
        check("t1_err", 32'(err), 32'h0);

        // Back-pressure: second completion is dropped as overrun
        frame_ready = 1'b0;
        exp_q.push_back({16'h4321, 4'h0, 4'h0});
        show_frame(16'h4321);
        show_frame(16'h4321);
        idle(4);
        check("t2_valid_held", 32'(frame_valid), 32'h1);
        check("t2_digits_held", 32'(digits), 32'h4321);
        check("t2_err_ovr", 32'(err), 32'h4);
        frame_ready = 1'b1;
        tick(2);
        check("t2_valid_drop", 32'(frame_valid), 32'h0);
        check("t2_digits_after", 32'(digits), 32'h4321);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("t2_err_clr", 32'(err), 32'h0);

        // Short digit does not commit
        show(0, 4'h5, 5);
        show(1, 4'h6, 5);
        show(2, 4'h7, 2);
        show(3, 4'h8, 5);
        idle(8);
        check("t3_no_frame", 32'(frame_valid), 32'h0);
        exp_q.push_back({16'h8765, 4'h0, 4'h0});
        show(2, 4'h7, 5);
        idle(6);
        check("t3_digits", 32'(digits), 32'h8765);

        // Multi-select error leaves seen untouched
        drive_raw(4'b0011, SEG_5, 1'b0, 4);
        idle(2);
        check("t4_err_multi", 32'(err), 32'h2);
        show(1, 4'h9, 5);
        show(2, 4'hA, 5);
        show(3, 4'hB, 5);
        idle(6);
        check("t4_no_frame", 32'(frame_valid), 32'h0);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("t4_err_clr", 32'(err), 32'h0);
        drive_raw(4'b0001, 7'h49, 1'b0, 5);
        idle(2);
        check("t4_err_bad", 32'(err), 32'h1);
        check("t4_bad_no_frame", 32'(frame_valid), 32'h0);
        exp_q.push_back({16'hBA90, 4'b0001, 4'b0001});
        drive_raw(4'b0001, SEG_BLANK, 1'b1, 5);
        idle(6);
        check("t4_blank", 32'(blank), 32'h1);
        check("t4_dp", 32'(dp), 32'h1);
        check("t4_digits", 32'(digits), 32'hBA90);

        // Mid-frame reset drops the partial frame
        show(0, 4'hC, 5);
        show(1, 4'hD, 5);
        show(2, 4'hE, 5);
        idle(1);
        rst = 1'b1;
        tick(2);
        check("t5_digits", 32'(digits), 32'h0);
        check("t5_valid", 32'(frame_valid), 32'h0);
        check("t5_blank", 32'(blank), 32'h0);
        check("t5_dp", 32'(dp), 32'h0);
        check("t5_err", 32'(err), 32'h0);
        rst = 1'b0;
        idle(2);
        show(3, 4'hF, 5);
        idle(8);
        check("t5_no_frame", 32'(frame_valid), 32'h0);
        check("sb_empty", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
